// File: rtl/slv_pkg.sv
// Shared types and defaults for the slave transaction monitor and its recovery sequencer.
package slv_pkg;

    localparam int unsigned MonCntWidth     = 4;
    localparam int unsigned MonPrescalerDiv = 64;
    localparam int unsigned MonMaxUniqIds   = 1;
    localparam int unsigned MonMaxTxnsPerId = 1;

    typedef enum logic [1:0] {
        SLV_IDLE    = 2'd0,
        SLV_FENCE   = 2'd1,
        SLV_RESET   = 2'd2,
        SLV_RECOVER = 2'd3
    } slv_rst_state_e;

    // Width needed to hold 0..uniq_ids*txns_per_id outstanding transactions.
    function automatic int unsigned out_cnt_width(input int unsigned uniq_ids,
                                                  input int unsigned txns_per_id);
        return $clog2(uniq_ids * txns_per_id + 1);
    endfunction

    localparam int unsigned OutCntWidth = out_cnt_width(MonMaxUniqIds, MonMaxTxnsPerId);

endpackage

// File: rtl/slv_tick_gen.sv
// Prescaler counting 0..Div-1 with synchronous restart; tick_o is high for the
// single cycle in which the count sits at Div-1.
module slv_tick_gen #(
    parameter int unsigned Div = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned W = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [W-1:0] Last = W'(Div - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || (cnt_q == Last)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == Last);

endmodule

// File: rtl/slv_rst_sequencer.sv
// Timeout recovery for the monitored AXI slave: fence AW/AR, drain with a
// bounded budget, pulse a dedicated slave reset, settle, then reopen the port.
module slv_rst_sequencer
    import slv_pkg::*;
#(
    parameter int unsigned MaxUniqIds   = 1,
    parameter int unsigned MaxTxnsPerId = 1,
    parameter int unsigned CntWidth     = MonCntWidth,
    parameter int unsigned PrescalerDiv = MonPrescalerDiv,
    parameter int unsigned OutCntWidth  = out_cnt_width(MaxUniqIds, MaxTxnsPerId)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic                   timeout_i,
    input  logic [OutCntWidth-1:0] w_outstanding_i,
    input  logic [OutCntWidth-1:0] r_outstanding_i,
    input  logic [CntWidth-1:0]    drain_budget_i,
    input  logic [CntWidth-1:0]    reset_cycles_i,
    input  logic                   irq_clr_i,
    output logic                   isolate_o,
    output logic                   slv_rst_o,
    output logic                   irq_o,
    output logic                   drain_timeout_o,
    output logic [1:0]             state_o,
    output logic [CntWidth-1:0]    seq_count_o
);

    slv_rst_state_e      state_q, state_d;
    logic [CntWidth-1:0] budget_q, budget_d;
    logic [CntWidth-1:0] rst_len_q, rst_len_d;
    logic [CntWidth-1:0] tick_cnt_q, tick_cnt_d;
    logic [CntWidth-1:0] seq_cnt_q, seq_cnt_d;
    logic                isolate_q, isolate_d;
    logic                slv_rst_q, slv_rst_d;
    logic                irq_q, irq_d;
    logic                dto_q, dto_d;
    logic                irq_set, dto_set;
    logic                restart, tick;
    logic                drained, expired;

    slv_tick_gen #(
        .Div (PrescalerDiv)
    ) u_tick_gen (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .restart_i (restart),
        .tick_o    (tick)
    );

    assign drained = (w_outstanding_i == '0) && (r_outstanding_i == '0);
    // Expiry looks at the count this tick would produce, so FENCE lasts exactly budget*PrescalerDiv cycles.
    assign expired = (budget_q == '0) || (tick && (tick_cnt_q == (budget_q - 1'b1)));

    always_comb begin
        state_d    = state_q;
        budget_d   = budget_q;
        rst_len_d  = rst_len_q;
        tick_cnt_d = tick_cnt_q;
        seq_cnt_d  = seq_cnt_q;
        restart    = 1'b0;
        irq_set    = 1'b0;
        dto_set    = 1'b0;

        unique case (state_q)
            SLV_IDLE: begin
                if (enable_i && timeout_i) begin
                    state_d    = SLV_FENCE;
                    budget_d   = drain_budget_i;
                    rst_len_d  = (reset_cycles_i == '0) ? CntWidth'(1) : reset_cycles_i;
                    tick_cnt_d = '0;
                    restart    = 1'b1;
                    irq_set    = 1'b1;
                end
            end
            SLV_FENCE: begin
                if (tick && (tick_cnt_q != '1)) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
                if (drained || expired) begin
                    state_d = SLV_RESET;
                    dto_set = !drained;
                end
            end
            SLV_RESET: begin
                // rst_len_q counts down the remaining reset cycles, including this one.
                if (rst_len_q == CntWidth'(1)) begin
                    state_d = SLV_RECOVER;
                    restart = 1'b1;
                end else begin
                    rst_len_d = rst_len_q - 1'b1;
                end
            end
            SLV_RECOVER: begin
                if (tick) begin
                    state_d = SLV_IDLE;
                    if (seq_cnt_q != '1) begin
                        seq_cnt_d = seq_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = SLV_IDLE;
        endcase

        irq_d     = irq_set | (irq_q & ~irq_clr_i);
        dto_d     = dto_set | (dto_q & ~irq_clr_i);
        isolate_d = (state_d != SLV_IDLE);
        slv_rst_d = (state_d == SLV_RESET);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= SLV_IDLE;
            budget_q   <= '0;
            rst_len_q  <= '0;
            tick_cnt_q <= '0;
            seq_cnt_q  <= '0;
            isolate_q  <= 1'b0;
            slv_rst_q  <= 1'b0;
            irq_q      <= 1'b0;
            dto_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            budget_q   <= budget_d;
            rst_len_q  <= rst_len_d;
            tick_cnt_q <= tick_cnt_d;
            seq_cnt_q  <= seq_cnt_d;
            isolate_q  <= isolate_d;
            slv_rst_q  <= slv_rst_d;
            irq_q      <= irq_d;
            dto_q      <= dto_d;
        end
    end

    assign isolate_o       = isolate_q;
    assign slv_rst_o       = slv_rst_q;
    assign irq_o           = irq_q;
    assign drain_timeout_o = dto_q;
    assign state_o         = state_q;
    assign seq_count_o     = seq_cnt_q;

endmodule
